// File: rtl/alu_mul_seq.sv
// Iterative unsigned shift-and-add multiplier controller.
// Owns the operand registers and FSM; every addition goes through the shared external ALU.
module alu_mul_seq #(
  parameter int WIDTH      = 16,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic             alu_op,
  input  logic [WIDTH-1:0] alu_result
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] product_q, product_d;
  logic [WIDTH-1:0] mplier_shr;
  logic             last_iter;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    count_d    = count_q;
    product_d  = product_q;
    mplier_shr = mplier_q >> 1;
    last_iter  = (count_q == LAST_COUNT) || (EARLY_EXIT && (mplier_shr == '0));

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d    = '0;
          mcand_d  = a;
          mplier_d = b;
          count_d  = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (mplier_q[0]) begin
          acc_d = alu_result;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_shr;
        count_d  = count_q + CW'(1);
        // The product captures this cycle's accumulator update, not the stale register.
        if (last_iter) begin
          product_d = acc_d;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);
  assign product = product_q;
  assign alu_in1 = acc_q;
  assign alu_in2 = mcand_q;
  assign alu_op  = 1'b0;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench for alu_mul_seq: stimulus pushes expected results, a monitor
// compares them whenever done pulses. A second EARLY_EXIT=0 instance checks fixed latency.
module tb_alu_mul_seq;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] prod;
    int           done_cyc;
    int           k;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] p;
    int           k;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         start0 = 1'b0;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;

  logic         busy, done, alu_op;
  logic [W-1:0] product, alu_in1, alu_in2, alu_res;
  logic         busy0, done0, alu_op0;
  logic [W-1:0] product0, alu_in1_0, alu_in2_0, alu_res0;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   n_done = 0;
  int   busy_cnt = 0;
  logic op_bad = 1'b0;
  exp_t sb_q[$];

  alu_mul_seq #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a_i), .b(b_i),
    .busy(busy), .done(done), .product(product),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op), .alu_result(alu_res)
  );

  alu_mul_seq #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .a(a_i), .b(b_i),
    .busy(busy0), .done(done0), .product(product0),
    .alu_in1(alu_in1_0), .alu_in2(alu_in2_0), .alu_op(alu_op0), .alu_result(alu_res0)
  );

  // Behavioural model of the shared add/sub ALU.
  assign alu_res  = alu_op  ? alu_in1 - alu_in2     : alu_in1 + alu_in2;
  assign alu_res0 = alu_op0 ? alu_in1_0 - alu_in2_0 : alu_in1_0 + alu_in2_0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: consumes one scoreboard entry per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy_cnt = 0;
      op_bad   = 1'b0;
    end else begin
      if (alu_op !== 1'b0) op_bad = 1'b1;
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        n_done++;
        if (sb_q.size() == 0) begin
          check("unexpected_done", product, 32'hDEAD_BEEF);
        end else begin
          e = sb_q.pop_front();
          check("product", product, e.prod);
          check("done_cycle", cyc, e.done_cyc);
          check("busy_cycles", busy_cnt, e.k);
          check("alu_op_zero", op_bad, 1'b0);
        end
        busy_cnt = 0;
      end
    end
  end

  // Done appears k edges after the accepting edge (cycle k+1 when the start edge is 0).
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] p, input int k);
    exp_t e;
    @(negedge clk);
    a_i   = av;
    b_i   = bv;
    start = 1'b1;
    e.prod = p;
    e.done_cyc = cyc + 1 + k;
    e.k = k;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle", sb_q.size(), 0);
    sb_q.delete();
  endtask

  vec_t vecs[7] = '{
    '{16'd3,    16'd5,    16'd15,   3},
    '{16'h1234, 16'h0000, 16'h0000, 1},
    '{16'hFFFF, 16'hFFFF, 16'h0001, 16},
    '{16'h00FF, 16'h0100, 16'hFF00, 9},
    '{16'h8000, 16'h0002, 16'h0000, 2},
    '{16'h1234, 16'h0001, 16'h1234, 1},
    '{16'hFFFD, 16'h0005, 16'hFFF1, 3}
  };

  vec_t vecs0[2] = '{
    '{16'd3,    16'd5,    16'd15,   16},
    '{16'h1234, 16'h0000, 16'h0000, 16}
  };

  initial begin
    int e_edge;
    int saved_done;

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_product", product, 16'h0000);
    check("rst_alu_in1", alu_in1, 16'h0000);
    check("rst_alu_in2", alu_in2, 16'h0000);
    check("rst_alu_op", alu_op, 1'b0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].k);
      wait_idle(40);
    end

    // Start held high: the DONE-cycle start is dropped, the following IDLE one is taken.
    @(negedge clk);
    a_i = 16'd7;
    b_i = 16'd9;
    start = 1'b1;
    e_edge = cyc + 1;
    sb_q.push_back('{16'd63, e_edge + 4, 4});
    sb_q.push_back('{16'd4, e_edge + 8, 2});
    repeat (2) @(negedge clk);
    a_i = 16'd2;
    b_i = 16'd2;
    while (cyc < e_edge + 6) @(negedge clk);
    start = 1'b0;
    wait_idle(40);

    // Reset during the third RUN cycle aborts without a done pulse.
    saved_done = n_done;
    @(negedge clk);
    a_i = 16'd100;
    b_i = 16'd200;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_product", product, 16'h0000);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_no_done", n_done, saved_done);
    check("abort_product_held", product, 16'h0000);
    issue(16'd6, 16'd7, 16'd42, 3);
    wait_idle(40);

    // Fixed-latency instance: every multiplier takes WIDTH iterations.
    foreach (vecs0[i]) begin
      int n = 0;
      @(negedge clk);
      a_i = vecs0[i].a;
      b_i = vecs0[i].b;
      start0 = 1'b1;
      e_edge = cyc + 1;
      @(negedge clk);
      start0 = 1'b0;
      while (done0 !== 1'b1 && n < 40) begin
        @(negedge clk);
        n++;
      end
      check("ee0_done_seen", done0, 1'b1);
      check("ee0_done_cycle", cyc - e_edge, vecs0[i].k);
      check("ee0_product", product0, vecs0[i].p);
      @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
